// File: rtl/video_timing_noise_gen.sv
// Raster timing source: pixel enable, sync/blank strobes and an LFSR greyscale
// noise pixel, with NTSC/PAL and scandouble geometry latched at frame start.
module video_timing_noise_gen #(
  parameter int          CE_DIV        = 4,
  parameter int          H_ACTIVE      = 320,
  parameter int          H_TOTAL       = 448,
  parameter int          HS_START      = 336,
  parameter int          HS_WIDTH      = 32,
  parameter int          V_ACTIVE      = 240,
  parameter int          V_TOTAL_NTSC  = 262,
  parameter int          V_TOTAL_PAL   = 312,
  parameter int          VS_START_NTSC = 244,
  parameter int          VS_START_PAL  = 270,
  parameter int          VS_WIDTH      = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic [7:0] video
);

  localparam int DIV_W = $clog2(CE_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST_N = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_S = DIV_W'(CE_DIV / 2 - 1);

  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] HS_BEG = 9'(HS_START);
  localparam logic [8:0] HS_END = 9'(HS_START + HS_WIDTH);

  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VT_N     = 10'(V_TOTAL_NTSC);
  localparam logic [9:0] VT_P     = 10'(V_TOTAL_PAL);
  localparam logic [9:0] VS_BEG_N = 10'(VS_START_NTSC);
  localparam logic [9:0] VS_BEG_P = 10'(VS_START_PAL);
  localparam logic [9:0] VS_W     = 10'(VS_WIDTH);

  logic [DIV_W-1:0] div_q;
  logic [8:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             pal_l_q, sd_l_q;
  logic             ce_q, hblank_q, hsync_q, vblank_q, vsync_q;
  logic [7:0]       video_q;

  logic             tick, h_wrap, v_wrap, frame_wrap;
  logic [9:0]       vt, v_last, src_line, vs_beg;
  logic             hblank_d, hsync_d, vblank_d, vsync_d, active_d;
  logic [7:0]       video_d;

  always_comb begin
    tick       = (div_q == (sd_l_q ? DIV_LAST_S : DIV_LAST_N));
    vt         = pal_l_q ? VT_P : VT_N;
    v_last     = (sd_l_q ? (vt << 1) : vt) - 10'd1;
    vs_beg     = pal_l_q ? VS_BEG_P : VS_BEG_N;
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == v_last);
    frame_wrap = h_wrap && v_wrap;

    h_d = h_wrap ? 9'd0 : h_q + 9'd1;
    v_d = v_q;
    if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;

    // Entering v=0 the source line is 0 regardless of which mode is latched next.
    src_line = sd_l_q ? (v_d >> 1) : v_d;

    hblank_d = (h_d >= H_ACT);
    hsync_d  = (h_d >= HS_BEG) && (h_d < HS_END);
    vblank_d = (src_line >= V_ACT);
    vsync_d  = (src_line >= vs_beg) && (src_line < vs_beg + VS_W);
    active_d = !hblank_d && !vblank_d;

    video_d = active_d ? lfsr_q[7:0] : 8'd0;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      lfsr_q   <= LFSR_SEED;
      pal_l_q  <= 1'b0;
      sd_l_q   <= 1'b0;
      ce_q     <= 1'b0;
      hblank_q <= 1'b1;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b1;
      vsync_q  <= 1'b0;
      video_q  <= 8'd0;
    end else begin
      ce_q <= tick;
      if (tick) begin
        div_q    <= '0;
        h_q      <= h_d;
        v_q      <= v_d;
        hblank_q <= hblank_d;
        hsync_q  <= hsync_d;
        vblank_q <= vblank_d;
        vsync_q  <= vsync_d;
        video_q  <= video_d;
        if (active_d) lfsr_q <= lfsr_d;
        if (frame_wrap) begin
          pal_l_q <= pal;
          sd_l_q  <= scandouble;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign ce_pix = ce_q;
  assign HBlank = hblank_q;
  assign HSync  = hsync_q;
  assign VBlank = vblank_q;
  assign VSync  = vsync_q;
  assign video  = video_q;

endmodule
